gbe_tx_packet_fifo: RTL and testbench

Parametrised transmit buffer between the yellow-block TX interface and the 100G core's AXI-Stream TX input. It replaces the tied-off `gbe_tx_afull` and the OR-ed `gbe_tx_valid` with real packet buffering. Each lane of the valid vector becomes a `tkeep` byte group. Packets are committed only on end-of-frame, so any packet that overflows the buffer is dropped whole. Downstream it presents one committed packet at a time, with per-packet destination IP and port, under standard AXIS handshaking.

---
 rtl/gbe_tx_packet_fifo.sv | 188 ++++++++++++++++++
 tb/tb_gbe_tx_packet_fifo.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gbe_tx_packet_fifo.sv
// rtl/gbe_tx_packet_fifo.sv - packet-committing TX buffer feeding the 100G core AXI-Stream input
// Words are written speculatively and only become readable once their EOF commits the packet.
module gbe_tx_packet_fifo #(
    parameter int DATA_WIDTH     = 512,
    parameter int VALID_WIDTH    = 4,
    parameter int DEPTH_LOG2     = 9,
    parameter int HDR_DEPTH_LOG2 = 4,
    parameter int AFULL_MARGIN   = 16
) (
    input  logic                      user_clk,
    input  logic                      axis_reset,
    input  logic                      enable,
    input  logic [DATA_WIDTH-1:0]     gbe_tx_data,
    input  logic [VALID_WIDTH-1:0]    gbe_tx_valid,
    input  logic                      gbe_tx_end_of_frame,
    input  logic [31:0]               gbe_tx_dest_ip,
    input  logic [15:0]               gbe_tx_dest_port,
    output logic                      gbe_tx_afull,
    output logic                      gbe_tx_overflow,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic [31:0]               m_axis_dest_ip,
    output logic [15:0]               m_axis_dest_port,
    output logic [31:0]               tx_packet_count,
    output logic [31:0]               tx_drop_count,
    output logic [DEPTH_LOG2:0]       fifo_level
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int LANE_BYTES = KEEP_WIDTH / VALID_WIDTH;
    localparam int ENTRY_W    = DATA_WIDTH + VALID_WIDTH + 1;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int HDR_DEPTH  = 1 << HDR_DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]     FULL_LEVEL  = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]     AFULL_LEVEL = FULL_LEVEL - AFULL_MARGIN[DEPTH_LOG2:0];
    localparam logic [HDR_DEPTH_LOG2:0] HDR_FULL    = {1'b1, {HDR_DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {W_ACCEPT, W_DROP, W_DISCARD} wr_state_t;
    typedef enum logic {R_IDLE, R_STREAM} rd_state_t;

    logic [ENTRY_W-1:0] mem     [DEPTH];
    logic [47:0]        hdr_mem [HDR_DEPTH];

    wr_state_t               wr_state, wr_next;
    rd_state_t               rd_state, rd_next;
    logic [DEPTH_LOG2:0]     wr_ptr, wr_commit, rd_ptr;
    logic [HDR_DEPTH_LOG2:0] hdr_wr, hdr_rd, hdr_count;
    logic                    in_pkt;
    logic                    word_in, eof, data_full, hdr_full, hdr_empty;
    logic                    wr_en, rewind, ovf, commit;
    logic                    load, take, pop;
    logic [DEPTH_LOG2-1:0]   rd_addr;
    logic [ENTRY_W-1:0]      rd_word;
    logic [VALID_WIDTH-1:0]  out_mask;

    assign word_in    = |gbe_tx_valid;
    assign eof        = gbe_tx_end_of_frame;
    assign fifo_level = wr_ptr - rd_ptr;
    assign data_full  = (fifo_level == FULL_LEVEL);
    assign hdr_count  = hdr_wr - hdr_rd;
    assign hdr_full   = (hdr_count == HDR_FULL);
    assign hdr_empty  = (hdr_wr == hdr_rd);
    assign commit     = wr_en && eof;

    always_comb begin
        wr_next = wr_state;
        wr_en   = 1'b0;
        rewind  = 1'b0;
        ovf     = 1'b0;
        case (wr_state)
            W_ACCEPT: begin
                if (word_in) begin
                    // The enable check applies only to the first word of a packet.
                    if (!in_pkt && !enable) begin
                        if (!eof) wr_next = W_DISCARD;
                    end else if (data_full || (eof && hdr_full)) begin
                        rewind = 1'b1;
                        ovf    = 1'b1;
                        if (!eof) wr_next = W_DROP;
                    end else begin
                        wr_en = 1'b1;
                    end
                end
            end
            W_DROP, W_DISCARD: begin
                if (word_in && eof) wr_next = W_ACCEPT;
            end
            default: wr_next = W_ACCEPT;
        endcase
    end

    always_ff @(posedge user_clk or posedge axis_reset) begin
        if (axis_reset) begin
            wr_state        <= W_ACCEPT;
            wr_ptr          <= '0;
            wr_commit       <= '0;
            hdr_wr          <= '0;
            in_pkt          <= 1'b0;
            tx_packet_count <= '0;
            tx_drop_count   <= '0;
            gbe_tx_overflow <= 1'b0;
            gbe_tx_afull    <= 1'b0;
        end else begin
            wr_state        <= wr_next;
            gbe_tx_overflow <= ovf;
            gbe_tx_afull    <= (fifo_level >= AFULL_LEVEL);
            if (rewind) begin
                wr_ptr <= wr_commit;
                in_pkt <= 1'b0;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                in_pkt <= !eof;
            end
            if (commit) begin
                wr_commit       <= wr_ptr + 1'b1;
                hdr_wr          <= hdr_wr + 1'b1;
                tx_packet_count <= tx_packet_count + 32'd1;
            end
            if (ovf) tx_drop_count <= tx_drop_count + 32'd1;
        end
    end

    always_ff @(posedge user_clk) begin
        if (wr_en) mem[wr_ptr[DEPTH_LOG2-1:0]] <= {gbe_tx_data, gbe_tx_valid, eof};
        if (commit) hdr_mem[hdr_wr[HDR_DEPTH_LOG2-1:0]] <= {gbe_tx_dest_ip, gbe_tx_dest_port};
    end

    // Prefetch address: the head word when idle, the word after the presented beat when streaming.
    assign rd_addr = (rd_state == R_IDLE) ? rd_ptr[DEPTH_LOG2-1:0]
                                          : rd_ptr[DEPTH_LOG2-1:0] + 1'b1;
    assign rd_word = mem[rd_addr];
    assign take    = m_axis_tvalid && m_axis_tready;

    always_comb begin
        rd_next = rd_state;
        load    = 1'b0;
        pop     = 1'b0;
        case (rd_state)
            R_IDLE: begin
                if (!hdr_empty) begin
                    load    = 1'b1;
                    rd_next = R_STREAM;
                end
            end
            R_STREAM: begin
                if (take && m_axis_tlast) begin
                    pop     = 1'b1;
                    rd_next = R_IDLE;
                end
            end
            default: rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge user_clk or posedge axis_reset) begin
        if (axis_reset) begin
            rd_state         <= R_IDLE;
            rd_ptr           <= '0;
            hdr_rd           <= '0;
            m_axis_tvalid    <= 1'b0;
            m_axis_tdata     <= '0;
            out_mask         <= '0;
            m_axis_tlast     <= 1'b0;
            m_axis_dest_ip   <= '0;
            m_axis_dest_port <= '0;
        end else begin
            rd_state <= rd_next;
            if (take) rd_ptr <= rd_ptr + 1'b1;
            if (pop) hdr_rd <= hdr_rd + 1'b1;
            if (load) begin
                m_axis_tvalid                        <= 1'b1;
                {m_axis_tdata, out_mask, m_axis_tlast} <= rd_word;
                {m_axis_dest_ip, m_axis_dest_port}   <= hdr_mem[hdr_rd[HDR_DEPTH_LOG2-1:0]];
            end else if (take) begin
                if (m_axis_tlast) m_axis_tvalid <= 1'b0;
                else {m_axis_tdata, out_mask, m_axis_tlast} <= rd_word;
            end
        end
    end

    for (genvar b = 0; b < KEEP_WIDTH; b++) begin : g_keep
        assign m_axis_tkeep[b] = out_mask[b / LANE_BYTES];
    end

endmodule

// File: tb/tb_gbe_tx_packet_fifo.sv
// tb/tb_gbe_tx_packet_fifo.sv - directed self-checking bench for gbe_tx_packet_fifo
module tb_gbe_tx_packet_fifo;

    logic         user_clk;
    logic         axis_reset;
    logic         enable;
    logic [511:0] gbe_tx_data;
    logic [3:0]   gbe_tx_valid;
    logic         gbe_tx_end_of_frame;
    logic [31:0]  gbe_tx_dest_ip;
    logic [15:0]  gbe_tx_dest_port;
    logic         gbe_tx_afull;
    logic         gbe_tx_overflow;
    logic [511:0] m_axis_tdata;
    logic [63:0]  m_axis_tkeep;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;
    logic [31:0]  m_axis_dest_ip;
    logic [15:0]  m_axis_dest_port;
    logic [31:0]  tx_packet_count;
    logic [31:0]  tx_drop_count;
    logic [4:0]   fifo_level;

    int checks = 0;
    int errors = 0;

    gbe_tx_packet_fifo #(
        .DATA_WIDTH(512), .VALID_WIDTH(4), .DEPTH_LOG2(4), .HDR_DEPTH_LOG2(2), .AFULL_MARGIN(4)
    ) dut (
        .user_clk(user_clk), .axis_reset(axis_reset), .enable(enable),
        .gbe_tx_data(gbe_tx_data), .gbe_tx_valid(gbe_tx_valid),
        .gbe_tx_end_of_frame(gbe_tx_end_of_frame), .gbe_tx_dest_ip(gbe_tx_dest_ip),
        .gbe_tx_dest_port(gbe_tx_dest_port), .gbe_tx_afull(gbe_tx_afull),
        .gbe_tx_overflow(gbe_tx_overflow), .m_axis_tdata(m_axis_tdata),
        .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .m_axis_dest_ip(m_axis_dest_ip), .m_axis_dest_port(m_axis_dest_port),
        .tx_packet_count(tx_packet_count), .tx_drop_count(tx_drop_count),
        .fifo_level(fifo_level)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [511:0] word(input int k);
        logic [31:0] v;
        v = 32'hC0DE0000 + 32'(k);
        return {16{v}};
    endfunction

    task automatic idle_in();
        gbe_tx_valid        = 4'h0;
        gbe_tx_end_of_frame = 1'b0;
    endtask

    task automatic drive(input logic [511:0] d, input logic [3:0] m, input logic e,
                         input logic [31:0] ip, input logic [15:0] port);
        gbe_tx_data         = d;
        gbe_tx_valid        = m;
        gbe_tx_end_of_frame = e;
        gbe_tx_dest_ip      = ip;
        gbe_tx_dest_port    = port;
        @(negedge user_clk);
    endtask

    task automatic do_reset();
        axis_reset    = 1'b1;
        enable        = 1'b1;
        m_axis_tready = 1'b0;
        gbe_tx_data   = '0;
        gbe_tx_dest_ip = '0;
        gbe_tx_dest_port = '0;
        idle_in();
        repeat (2) @(negedge user_clk);
        axis_reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b exp 0", m_axis_tvalid); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast got %b exp 0", m_axis_tlast); end
        checks++; if (m_axis_tdata !== 512'd0) begin errors++; $display("FAIL rst_tdata got %h exp 0", m_axis_tdata); end
        checks++; if (m_axis_tkeep !== 64'd0) begin errors++; $display("FAIL rst_tkeep got %h exp 0", m_axis_tkeep); end
        checks++; if ({m_axis_dest_ip, m_axis_dest_port} !== 48'd0) begin errors++; $display("FAIL rst_dest got %h:%h exp 0", m_axis_dest_ip, m_axis_dest_port); end
        checks++; if ({gbe_tx_afull, gbe_tx_overflow} !== 2'b00) begin errors++; $display("FAIL rst_flags got %b%b exp 00", gbe_tx_afull, gbe_tx_overflow); end
        checks++; if ({tx_packet_count, tx_drop_count} !== 64'd0) begin errors++; $display("FAIL rst_counts got %0d/%0d exp 0/0", tx_packet_count, tx_drop_count); end
        checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", fifo_level); end
    endtask

    task automatic test_basic_packet();
        do_reset();
        m_axis_tready = 1'b1;
        drive(word(1), 4'hF, 1'b0, 32'h0A000002, 16'd10000);
        drive(word(2), 4'hF, 1'b0, 32'h0A000002, 16'd10000);
        drive(word(3), 4'b0011, 1'b1, 32'h0A000002, 16'd10000);
        idle_in();
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL basic_n1_tvalid got %b exp 0", m_axis_tvalid); end
        @(negedge user_clk);
        checks++; if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== {1'b1, word(1), 64'hFFFF_FFFF_FFFF_FFFF, 1'b0})
            begin errors++; $display("FAIL basic_beat0 got v=%b keep=%h last=%b data=%h", m_axis_tvalid, m_axis_tkeep, m_axis_tlast, m_axis_tdata); end
        @(negedge user_clk);
        checks++; if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast} !== {1'b1, word(2), 1'b0})
            begin errors++; $display("FAIL basic_beat1 got v=%b last=%b data=%h", m_axis_tvalid, m_axis_tlast, m_axis_tdata); end
        @(negedge user_clk);
        checks++; if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== {1'b1, word(3), 64'h0000_0000_FFFF_FFFF, 1'b1})
            begin errors++; $display("FAIL basic_beat2 got v=%b keep=%h last=%b", m_axis_tvalid, m_axis_tkeep, m_axis_tlast); end
        checks++; if ({m_axis_dest_ip, m_axis_dest_port} !== {32'h0A000002, 16'd10000})
            begin errors++; $display("FAIL basic_dest got %h:%0d exp 0a000002:10000", m_axis_dest_ip, m_axis_dest_port); end
        @(negedge user_clk);
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL basic_after_tvalid got %b exp 0", m_axis_tvalid); end
        checks++; if (tx_packet_count !== 32'd1) begin errors++; $display("FAIL basic_pkt_count got %0d exp 1", tx_packet_count); end
        checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL basic_level got %0d exp 0", fifo_level); end
    endtask

    task automatic test_almost_full();
        do_reset();
        for (int i = 0; i < 11; i++) drive(word(100 + i), 4'hF, 1'b0, 32'h0, 16'h0);
        checks++; if (gbe_tx_afull !== 1'b0) begin errors++; $display("FAIL afull_early got %b exp 0", gbe_tx_afull); end
        drive(word(111), 4'hF, 1'b0, 32'h0, 16'h0);
        idle_in();
        checks++; if (fifo_level !== 5'd12) begin errors++; $display("FAIL afull_level got %0d exp 12", fifo_level); end
        @(negedge user_clk);
        checks++; if (gbe_tx_afull !== 1'b1) begin errors++; $display("FAIL afull_flag got %b exp 1", gbe_tx_afull); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL afull_no_output got %b exp 0", m_axis_tvalid); end
    endtask

    task automatic test_data_overflow();
        int n;
        do_reset();
        for (int i = 0; i < 17; i++) drive(word(200 + i), 4'hF, (i == 16), 32'h0A000009, 16'd9);
        idle_in();
        checks++; if (gbe_tx_overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse got %b exp 1", gbe_tx_overflow); end
        checks++; if (tx_drop_count !== 32'd1) begin errors++; $display("FAIL ovf_drop_count got %0d exp 1", tx_drop_count); end
        checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL ovf_level got %0d exp 0", fifo_level); end
        @(negedge user_clk);
        checks++; if (gbe_tx_overflow !== 1'b0) begin errors++; $display("FAIL ovf_pulse_width got %b exp 0", gbe_tx_overflow); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL ovf_no_output got %b exp 0", m_axis_tvalid); end
        m_axis_tready = 1'b1;
        drive(word(60), 4'hF, 1'b0, 32'h0A000005, 16'd5);
        drive(word(61), 4'h1, 1'b1, 32'h0A000005, 16'd5);
        idle_in();
        n = 0;
        for (int c = 0; c < 10; c++) begin
            if (m_axis_tvalid && m_axis_tready) begin
                checks++; if ({m_axis_tdata, m_axis_tlast} !== {word(60 + n), (n == 1)})
                    begin errors++; $display("FAIL ovf_next_beat%0d got last=%b data=%h", n, m_axis_tlast, m_axis_tdata); end
                n++;
            end
            @(negedge user_clk);
        end
        checks++; if (n !== 2) begin errors++; $display("FAIL ovf_next_beats got %0d exp 2", n); end
        checks++; if (tx_packet_count !== 32'd1) begin errors++; $display("FAIL ovf_pkt_count got %0d exp 1", tx_packet_count); end
    endtask

    task automatic test_header_full();
        int n;
        do_reset();
        for (int k = 0; k < 5; k++) drive(word(40 + k), 4'hF, 1'b1, 32'h0A000010 + 32'(k), 16'(2000 + k));
        idle_in();
        checks++; if (gbe_tx_overflow !== 1'b1) begin errors++; $display("FAIL hdr_ovf_pulse got %b exp 1", gbe_tx_overflow); end
        checks++; if (tx_drop_count !== 32'd1) begin errors++; $display("FAIL hdr_drop_count got %0d exp 1", tx_drop_count); end
        checks++; if (fifo_level !== 5'd4) begin errors++; $display("FAIL hdr_level got %0d exp 4", fifo_level); end
        checks++; if (tx_packet_count !== 32'd4) begin errors++; $display("FAIL hdr_pkt_count got %0d exp 4", tx_packet_count); end
        m_axis_tready = 1'b1;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            if (m_axis_tvalid && m_axis_tready) begin
                checks++; if ({m_axis_tdata, m_axis_tlast, m_axis_dest_ip, m_axis_dest_port} !== {word(40 + n), 1'b1, 32'h0A000010 + 32'(n), 16'(2000 + n)})
                    begin errors++; $display("FAIL hdr_pkt%0d got ip=%h port=%0d last=%b", n, m_axis_dest_ip, m_axis_dest_port, m_axis_tlast); end
                n++;
            end
            @(negedge user_clk);
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL hdr_pkt_total got %0d exp 4", n); end
    endtask

    task automatic test_backpressure();
        logic [511:0] h_data;
        logic [63:0]  h_keep;
        logic         h_last, stall;
        logic [31:0]  h_ip;
        logic [15:0]  h_port;
        int n;
        do_reset();
        stall = 1'b0; n = 0;
        h_data = '0; h_keep = '0; h_last = 1'b0; h_ip = '0; h_port = '0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    drive(word(20 + i), 4'hF, (i == 3) || (i == 7), (i < 4) ? 32'h0A000003 : 32'h0A000004, (i < 4) ? 16'd3000 : 16'd3001);
                idle_in();
            end
            begin
                for (int c = 0; c < 60; c++) begin
                    if (stall) begin
                        checks++; if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_dest_ip, m_axis_dest_port} !== {1'b1, h_data, h_keep, h_last, h_ip, h_port})
                            begin errors++; $display("FAIL bp_stable cycle %0d got v=%b data=%h exp held %h", c, m_axis_tvalid, m_axis_tdata, h_data); end
                    end
                    m_axis_tready = ~m_axis_tready;
                    if (m_axis_tvalid && m_axis_tready) begin
                        checks++;
                        if (n >= 8) begin errors++; $display("FAIL bp_extra_beat got %0d beats exp 8", n + 1); end
                        else if ({m_axis_tdata, m_axis_tlast, m_axis_dest_ip, m_axis_dest_port} !== {word(20 + n), (n == 3) || (n == 7), (n < 4) ? 32'h0A000003 : 32'h0A000004, (n < 4) ? 16'd3000 : 16'd3001})
                            begin errors++; $display("FAIL bp_beat%0d got last=%b ip=%h data=%h", n, m_axis_tlast, m_axis_dest_ip, m_axis_tdata); end
                        n++;
                    end
                    stall  = m_axis_tvalid && !m_axis_tready;
                    h_data = m_axis_tdata; h_keep = m_axis_tkeep; h_last = m_axis_tlast;
                    h_ip   = m_axis_dest_ip; h_port = m_axis_dest_port;
                    @(negedge user_clk);
                end
            end
        join
        checks++; if (n !== 8) begin errors++; $display("FAIL bp_total got %0d exp 8", n); end
        checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL bp_level got %0d exp 0", fifo_level); end
    endtask

    task automatic test_reset_and_disable();
        int n;
        bit seen;
        do_reset();
        drive(word(70), 4'hF, 1'b0, 32'h0A000007, 16'd7);
        drive(word(71), 4'hF, 1'b1, 32'h0A000007, 16'd7);
        idle_in();
        seen = 0;
        for (int c = 0; c < 6 && !seen; c++) begin
            if (m_axis_tvalid) seen = 1;
            else @(negedge user_clk);
        end
        checks++; if (!seen) begin errors++; $display("FAIL rd_wait_tvalid got 0 exp 1 within 6 cycles"); end
        #2 axis_reset = 1'b1;
        #1;
        checks++; if ({m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== {1'b0, 1'b0, 64'd0, 512'd0})
            begin errors++; $display("FAIL rd_async_out got v=%b last=%b keep=%h", m_axis_tvalid, m_axis_tlast, m_axis_tkeep); end
        checks++; if ({m_axis_dest_ip, m_axis_dest_port, tx_packet_count, fifo_level} !== {48'd0, 32'd0, 5'd0})
            begin errors++; $display("FAIL rd_async_state got ip=%h cnt=%0d lvl=%0d exp 0", m_axis_dest_ip, tx_packet_count, fifo_level); end
        @(negedge user_clk);
        axis_reset = 1'b0;
        m_axis_tready = 1'b1;
        drive(word(72), 4'hF, 1'b1, 32'h0A000008, 16'd8);
        idle_in();
        n = 0;
        for (int c = 0; c < 6; c++) begin
            if (m_axis_tvalid) begin
                checks++; if ({m_axis_tdata, m_axis_tlast, m_axis_dest_ip} !== {word(72), 1'b1, 32'h0A000008})
                    begin errors++; $display("FAIL rd_post_reset_beat got last=%b data=%h", m_axis_tlast, m_axis_tdata); end
                n++;
            end
            @(negedge user_clk);
        end
        checks++; if (n !== 1) begin errors++; $display("FAIL rd_post_reset_beats got %0d exp 1", n); end
        enable = 1'b0;
        drive(word(73), 4'hF, 1'b0, 32'h0A000009, 16'd9);
        enable = 1'b1;
        drive(word(74), 4'hF, 1'b0, 32'h0A000009, 16'd9);
        drive(word(75), 4'h3, 1'b1, 32'h0A000009, 16'd9);
        idle_in();
        n = 0;
        for (int c = 0; c < 8; c++) begin
            if (m_axis_tvalid || gbe_tx_overflow) n++;
            @(negedge user_clk);
        end
        checks++; if (n !== 0) begin errors++; $display("FAIL dis_no_output got %0d active cycles exp 0", n); end
        checks++; if ({tx_packet_count, tx_drop_count, fifo_level} !== {32'd1, 32'd0, 5'd0})
            begin errors++; $display("FAIL dis_counts got pkt=%0d drop=%0d lvl=%0d exp 1/0/0", tx_packet_count, tx_drop_count, fifo_level); end
        drive(word(76), 4'hF, 1'b1, 32'h0A00000A, 16'd10);
        idle_in();
        n = 0;
        for (int c = 0; c < 6; c++) begin
            if (m_axis_tvalid) begin
                checks++; if ({m_axis_tdata, m_axis_tlast} !== {word(76), 1'b1})
                    begin errors++; $display("FAIL dis_after_beat got last=%b data=%h", m_axis_tlast, m_axis_tdata); end
                n++;
            end
            @(negedge user_clk);
        end
        checks++; if (n !== 1) begin errors++; $display("FAIL dis_after_beats got %0d exp 1", n); end
    endtask

    initial begin
        test_reset();
        test_basic_packet();
        test_almost_full();
        test_data_overflow();
        test_header_full();
        test_backpressure();
        test_reset_and_disable();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
